// File: rtl/vga_frame_writer.sv
// Stream-to-framebuffer write stage: numbers incoming pixels with linear RAM
// addresses, buffers them in a small FIFO and drains it whenever the RAM port is granted.
module vga_frame_writer #(
    parameter int Wight      = 640,
    parameter int Height     = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] s_data,
    input  logic        s_sof,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        ram_grant,
    output logic        ram_wr_en,
    output logic [18:0] ram_wr_addr,
    output logic [11:0] ram_wr_data,
    output logic        frame_done,
    output logic        sof_error,
    output logic        busy
);
    localparam int AW = 19;
    localparam int XW = (Wight > 1) ? $clog2(Wight) : 1;
    localparam int YW = (Height > 1) ? $clog2(Height) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {WAIT_SOF, FILL} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
        logic          last;
    } entry_t;

    state_t        state, state_nxt;
    logic [XW-1:0] x_q, x_nxt, cur_x;
    logic [YW-1:0] y_q, y_nxt, cur_y;
    logic [AW-1:0] addr_q, addr_nxt, cur_addr;

    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        push_entry, head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_full, fifo_empty;
    logic          accept, push, pop, is_last, x_end, sof_err_nxt;

    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign s_ready    = !fifo_full;
    assign accept     = s_valid && s_ready;
    assign pop        = !fifo_empty && ram_grant;
    assign head       = fifo_mem[rd_ptr];
    assign busy       = (state == FILL) || !fifo_empty;

    // An SOF beat always lands at pixel 0, regardless of where the counters were.
    assign cur_x    = s_sof ? '0 : x_q;
    assign cur_y    = s_sof ? '0 : y_q;
    assign cur_addr = s_sof ? '0 : addr_q;
    assign x_end    = (cur_x == XW'(Wight - 1));
    assign is_last  = x_end && (cur_y == YW'(Height - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= WAIT_SOF;
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            addr_q <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        x_nxt       = x_q;
        y_nxt       = y_q;
        addr_nxt    = addr_q;
        push        = 1'b0;
        push_entry  = '0;
        sof_err_nxt = 1'b0;
        if (accept && (s_sof || state == FILL)) begin
            push        = 1'b1;
            push_entry  = '{addr: cur_addr, data: s_data, last: is_last};
            sof_err_nxt = s_sof && (state == FILL);
            if (is_last) begin
                state_nxt = WAIT_SOF;
                x_nxt     = '0;
                y_nxt     = '0;
                addr_nxt  = '0;
            end else begin
                state_nxt = FILL;
                x_nxt     = x_end ? '0 : cur_x + XW'(1);
                y_nxt     = x_end ? cur_y + YW'(1) : cur_y;
                addr_nxt  = cur_addr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_entry;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Address/data hold their last written values between strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_wr_en   <= 1'b0;
            ram_wr_addr <= '0;
            ram_wr_data <= '0;
            frame_done  <= 1'b0;
            sof_error   <= 1'b0;
        end else begin
            ram_wr_en  <= pop;
            frame_done <= pop && head.last;
            sof_error  <= sof_err_nxt;
            if (pop) begin
                ram_wr_addr <= head.addr;
                ram_wr_data <= head.data;
            end
        end
    end
endmodule

// File: tb/tb_vga_frame_writer.sv
// Directed bench for vga_frame_writer on an 8x4 frame; a scoreboard queue holds
// expected RAM writes and a negedge monitor checks every write strobe against it.
module tb_vga_frame_writer;
    localparam int W = 8;
    localparam int H = 4;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [18:0] addr;
        logic [11:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] s_data = '0;
    logic        s_sof = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        ram_grant = 1'b0;
    logic        ram_wr_en;
    logic [18:0] ram_wr_addr;
    logic [11:0] ram_wr_data;
    logic        frame_done;
    logic        sof_error;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   first_wr_cyc = -1;
    bit   want_lat = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    int   serr_cnt = 0;
    exp_t exp_q[$];

    vga_frame_writer #(.Wight(W), .Height(H), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
        .s_ready(s_ready), .ram_grant(ram_grant), .ram_wr_en(ram_wr_en),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .frame_done(frame_done), .sof_error(sof_error), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            if (sof_error) serr_cnt++;
            if (frame_done) done_cnt++;
            if (ram_wr_en) begin
                exp_t e;
                wr_cnt++;
                if (want_lat && first_wr_cyc < 0) first_wr_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected got addr=%0d data=%h", ram_wr_addr, ram_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (ram_wr_addr !== e.addr || ram_wr_data !== e.data || frame_done !== e.last) begin
                        errors++;
                        $display("FAIL wr_entry got addr=%0d data=%h done=%b want addr=%0d data=%h done=%b",
                                 ram_wr_addr, ram_wr_data, frame_done, e.addr, e.data, e.last);
                    end
                end
            end else if (frame_done) begin
                checks++;
                errors++;
                $display("FAIL done_without_write got frame_done=1 want 0");
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic send(input logic [11:0] d, input logic sof, input bit exp,
                        input int a, input bit last);
        int t = 0;
        exp_t e;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (!s_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got s_ready=0 want 1");
        end else begin
            acc_cyc = cyc;
            if (exp) begin
                e.addr = a[18:0];
                e.data = d;
                e.last = last;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1 s_valid = 1'b0;
        s_sof = 1'b0;
    endtask

    task automatic send_frame(input logic [11:0] base, input int from, input int upto);
        for (int i = from; i < upto; i++)
            send(base + 12'(i), i == 0, 1, i, i == NPIX - 1);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0, s0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", ram_wr_en, 0);
        check("rst_addr", ram_wr_addr, 0);
        check("rst_data", ram_wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sof_error", sof_error, 0);
        check("rst_busy", busy, 0);
        check("rst_s_ready", s_ready, 1);
        rst = 1'b1;
        ram_grant = 1'b1;

        // Full frame at one pixel per clock; covers line wrap 7 -> 8.
        want_lat = 1;
        send_frame(12'h100, 0, 1);
        d0 = acc_cyc;
        send_frame(12'h100, 1, NPIX);
        drain("frame1_drain");
        want_lat = 0;
        check("frame1_latency", first_wr_cyc - d0, 2);
        check("frame1_writes", wr_cnt, NPIX);
        check("frame1_done", done_cnt, 1);
        check("frame1_idle_busy", busy, 0);

        // Garbage before SOF is consumed but never written.
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) begin
            send(12'hBAD, 1'b0, 0, 0, 0);
            check("garbage_ready", s_ready, 1);
        end
        repeat (4) @(negedge clk);
        check("garbage_no_write", wr_cnt - w0, 0);
        send_frame(12'h200, 0, NPIX);
        drain("frame2_drain");
        check("frame2_done", done_cnt, 2);

        // Back-pressure: four accepts fill the FIFO, nothing written while ungranted.
        ram_grant = 1'b0;
        w0 = wr_cnt;
        send_frame(12'h300, 0, 4);
        @(negedge clk);
        check("bp_ready_low", s_ready, 0);
        check("bp_busy", busy, 1);
        repeat (10) @(negedge clk);
        check("bp_no_write", wr_cnt - w0, 0);
        check("bp_still_full", s_ready, 0);
        ram_grant = 1'b1;
        send_frame(12'h300, 4, NPIX);
        drain("bp_drain");
        check("bp_writes", wr_cnt - w0, NPIX);
        check("bp_done", done_cnt, 3);

        // Early SOF after 10 beats aborts the first frame.
        s0 = serr_cnt;
        send_frame(12'h400, 0, 10);
        send_frame(12'h500, 0, NPIX);
        drain("early_drain");
        check("early_sof_error", serr_cnt - s0, 1);
        check("early_done", done_cnt, 4);

        // Async reset with three entries buffered.
        ram_grant = 1'b0;
        send_frame(12'h600, 0, 3);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("arst_wr_en", ram_wr_en, 0);
        check("arst_addr", ram_wr_addr, 0);
        check("arst_data", ram_wr_data, 0);
        check("arst_busy", busy, 0);
        check("arst_s_ready", s_ready, 1);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        ram_grant = 1'b1;
        w0 = wr_cnt;
        repeat (5) @(negedge clk);
        check("arst_no_write", wr_cnt - w0, 0);
        for (int i = 0; i < 3; i++) send(12'h6AA, 1'b0, 0, 0, 0);
        repeat (5) @(negedge clk);
        check("arst_discard", wr_cnt - w0, 0);
        send_frame(12'h700, 0, 4);
        drain("arst_drain");
        check("arst_writes", wr_cnt - w0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_frame_writer.md
# vga_frame_writer

Stream-to-framebuffer write stage feeding the 640x480 RGB444 pixel RAM that the VGA read side scans. Accepts a valid/ready pixel stream with a start-of-frame flag, assigns each pixel a linear RAM address, and buffers pixels in a small FIFO. Drains the FIFO into the RAM write port whenever the RAM arbiter grants access. Reports frame completion and malformed frames.

## Interface
- Wight, 640: pixels per line.
- Height, 480: lines per frame.
- FIFO_DEPTH, 4: pixel FIFO entries (power of two, >= 2).
- clk  input  1  pixel/system clock; all logic rising-edge.
- rst  input  1  reset, asynchronous, active-low.
- s_data  input  12  pixel {R[3:0],G[3:0],B[3:0]}.
- s_sof  input  1  beat is first pixel of a frame.
- s_valid  input  1  beat valid.
- s_ready  output  1  beat accepted when s_valid && s_ready.
- ram_grant  input  1  RAM write port available this cycle.
- ram_wr_en  output  1  registered write strobe.
- ram_wr_addr  output  19  registered linear address, y*Wight + x, 0..Wight*Height-1.
- ram_wr_data  output  12  registered pixel.
- frame_done  output  1  one-cycle pulse: last pixel of a frame written to RAM.
- sof_error  output  1  one-cycle pulse: SOF received before previous frame completed.
- busy  output  1  input state is FILL or FIFO non-empty.

## Operation
- Input FSM, two states: WAIT_SOF (reset) and FILL.
- s_ready = !fifo_full in both states; no bypass of a full FIFO.
- WAIT_SOF: accepted beat with s_sof=0 is discarded. Accepted beat with s_sof=1 is pushed with address 0, x=1, y=0, addr=1. Go to FILL.
- FILL: each accepted beat is pushed as {addr, data}.
  - x increments; at x==Wight-1, x wraps to 0 and y increments.
  - addr increments by 1. Computed incrementally; no multiplier.
- Last pixel (x==Wight-1, y==Height-1) accepted -> its entry is tagged last; FSM returns to WAIT_SOF.
- Accepted beat with s_sof=1 in FILL:
  - pulse sof_error next cycle;
  - push beat as address 0 of a new frame; restart counters as in WAIT_SOF;
  - stay in FILL;
  - pixels already in the FIFO are still written.
- FIFO entry: 19-bit addr, 12-bit data, 1-bit last.
- Output side: at each edge with FIFO non-empty and ram_grant=1, pop head and register ram_wr_en=1, ram_wr_addr, ram_wr_data. Otherwise ram_wr_en=0. Address and data hold their last values.
- frame_done asserts in the same cycle as the ram_wr_en of the last-tagged entry.
- Push and pop in the same edge are allowed; occupancy is unchanged.

## Timing
- Reset (async assert, sync release):
  - FSM = WAIT_SOF, FIFO flushed, counters 0;
  - ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, frame_done=0, sof_error=0, busy=0;
  - s_ready=1.
- Reset mid-frame drops all buffered pixels and in-progress frame state. The next frame starts only at the next SOF.
- Latency: beat accepted at edge N -> ram_wr_en high after edge N+1 if ram_grant=1 during cycle N+1.
- Throughput: 1 pixel/clock with ram_grant held high. FIFO never fills.
- ram_grant low: FIFO fills after FIFO_DEPTH accepts; s_ready drops in the cycle after the filling edge. No beat is lost or duplicated.
- sof_error is a single pulse per offending beat, registered one cycle after acceptance.
- Address range: never exceeds Wight*Height-1. Wrap from 307199 goes back to 0 only via SOF.

## Test plan
- Full frame, ram_grant=1, SOF on beat 0, 307200 beats at 1/clk:
  - 307200 writes, addresses 0..307199 in order, data matches;
  - frame_done pulses once with addr 307199;
  - first ram_wr_en 2 cycles after first accept.
- Pre-SOF garbage: 5 beats with s_sof=0, then SOF frame -> garbage beats consumed (s_ready=1) and never written; first write is addr 0 with the SOF data.
- Back-pressure: ram_grant=0 for 10 cycles while streaming.
  - s_ready low after 4 accepts;
  - after ram_grant returns, writes resume at addr 0..3 then 4..;
  - no gaps or duplicates.
- Line wrap: check writes for x=639,y=0 -> addr 639 and x=0,y=1 -> addr 640.
- Early SOF: SOF at beat 1000 of a frame.
  - sof_error pulses once;
  - addrs 0..999 written, then addr 0 with the new SOF data;
  - no frame_done for the aborted frame.
- Async reset mid-frame with FIFO holding 3 entries:
  - all outputs 0 immediately, no further writes;
  - after release, non-SOF beats are discarded until the next SOF.
